adjust_ctrl_fsm: RTL and testbench

ADJUST_CTRL_FSM -- requirements
Module: adjust_ctrl_fsm

---
 rtl/adjust_pkg.sv | 33 +++
 rtl/adj_ms_timer.sv | 30 +++
 rtl/adjust_ctrl_fsm.sv | 164 ++++++++++++++++
 tb/tb_adjust_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adjust_pkg.sv
// Shared types and default timing for the time-adjust controller.
// Holds the FSM state encoding, the hold direction and the ms counter width helper.
package adjust_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_ADJUST      = 2'd1,
    ST_HOLD_DELAY  = 2'd2,
    ST_HOLD_REPEAT = 2'd3
  } adj_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } adj_dir_e;

  localparam int unsigned DEF_REPEAT_DELAY_MS = 500;
  localparam int unsigned DEF_REPEAT_RATE_MS  = 100;
  localparam int unsigned DEF_TIMEOUT_MS      = 30000;
  localparam int unsigned DEF_BLINK_HALF_MS   = 250;

  // Width that holds the largest of the four ms intervals.
  function automatic int unsigned ms_width(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/adj_ms_timer.sv
// Millisecond interval counter: advances on tick_ms while enabled, restarts on clr,
// and strobes done on the tick that reaches term, wrapping back to zero.
module adj_ms_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_ms,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] count;

  assign done = en && tick_ms && !clr && (count == term - W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && tick_ms) begin
      count <= done ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/adjust_ctrl_fsm.sv
// Clock-adjust mode controller: enters/leaves adjust, turns UP/DOWN presses into
// single and auto-repeat step pulses, blinks the selected field and times out to RUN.
module adjust_ctrl_fsm
  import adjust_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int unsigned REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
  parameter int unsigned TIMEOUT_MS      = DEF_TIMEOUT_MS,
  parameter int unsigned BLINK_HALF_MS   = DEF_BLINK_HALF_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic mode_pulse,
  input  logic sel_in,
  input  logic up_lvl,
  input  logic down_lvl,
  output logic adj_active,
  output logic run_en,
  output logic sel_pulse,
  output logic up_pulse,
  output logic down_pulse,
  output logic blink,
  output logic timeout_pulse
);

  localparam int unsigned CW = ms_width(REPEAT_DELAY_MS, REPEAT_RATE_MS,
                                        TIMEOUT_MS, BLINK_HALF_MS);
  localparam logic [CW-1:0] DELAY_T   = CW'(REPEAT_DELAY_MS);
  localparam logic [CW-1:0] RATE_T    = CW'(REPEAT_RATE_MS);
  localparam logic [CW-1:0] TIMEOUT_T = CW'(TIMEOUT_MS);
  localparam logic [CW-1:0] BLINK_T   = CW'(BLINK_HALF_MS);

  adj_state_e    state;
  adj_dir_e      dir;
  logic          up_q, down_q;
  logic          up_rise, down_rise;
  logic          in_adjust, in_hold, dir_lvl;
  logic          press_go, sel_go, rpt_go, activity;
  logic          hold_clr, to_clr, blink_clr, blink_en;
  logic [CW-1:0] hold_term;
  logic          hold_done, to_done, blink_done;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    up_rise   = up_lvl && !up_q;
    down_rise = down_lvl && !down_q;
    in_adjust = (state == ST_ADJUST);
    in_hold   = (state == ST_HOLD_DELAY) || (state == ST_HOLD_REPEAT);
    dir_lvl   = (dir == DIR_UP) ? up_lvl : down_lvl;
    press_go  = in_adjust && !mode_pulse && (up_rise || down_rise);
    sel_go    = in_adjust && !mode_pulse && sel_in;
    rpt_go    = in_hold && !mode_pulse && dir_lvl && hold_done;
    activity  = press_go || sel_go || rpt_go;
    hold_clr  = !in_hold || mode_pulse;
    hold_term = (state == ST_HOLD_DELAY) ? DELAY_T : RATE_T;
    to_clr    = (state == ST_RUN) || mode_pulse || activity;
    blink_clr = (state == ST_RUN) || mode_pulse || activity;
    blink_en  = (state != ST_RUN);
  end

  adj_ms_timer #(.W(CW)) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .tick_ms (tick_ms),
    .en      (in_hold),
    .clr     (hold_clr),
    .term    (hold_term),
    .done    (hold_done)
  );

  adj_ms_timer #(.W(CW)) u_timeout_timer (
    .clk     (clk),
    .rst     (rst),
    .tick_ms (tick_ms),
    .en      (in_adjust),
    .clr     (to_clr),
    .term    (TIMEOUT_T),
    .done    (to_done)
  );

  adj_ms_timer #(.W(CW)) u_blink_timer (
    .clk     (clk),
    .rst     (rst),
    .tick_ms (tick_ms),
    .en      (blink_en),
    .clr     (blink_clr),
    .term    (BLINK_T),
    .done    (blink_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      dir           <= DIR_UP;
      up_q          <= 1'b0;
      down_q        <= 1'b0;
      run_en        <= 1'b1;
      adj_active    <= 1'b0;
      blink         <= 1'b1;
      sel_pulse     <= 1'b0;
      up_pulse      <= 1'b0;
      down_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      up_q          <= up_lvl;
      down_q        <= down_lvl;
      sel_pulse     <= 1'b0;
      up_pulse      <= 1'b0;
      down_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;

      if (state == ST_RUN) begin
        if (mode_pulse) begin
          state      <= ST_ADJUST;
          run_en     <= 1'b0;
          adj_active <= 1'b1;
          blink      <= 1'b1;
        end
      end else if (mode_pulse) begin
        // Leaving adjust wins over any press, repeat, select or timeout this cycle.
        state      <= ST_RUN;
        run_en     <= 1'b1;
        adj_active <= 1'b0;
        blink      <= 1'b1;
      end else begin
        if (activity)        blink <= 1'b1;
        else if (blink_done) blink <= !blink;

        case (state)
          ST_ADJUST: begin
            sel_pulse <= sel_in;
            if (up_rise) begin
              up_pulse <= 1'b1;
              dir      <= DIR_UP;
              state    <= ST_HOLD_DELAY;
            end else if (down_rise) begin
              down_pulse <= 1'b1;
              dir        <= DIR_DOWN;
              state      <= ST_HOLD_DELAY;
            end else if (to_done) begin
              state         <= ST_RUN;
              timeout_pulse <= 1'b1;
              run_en        <= 1'b1;
              adj_active    <= 1'b0;
              blink         <= 1'b1;
            end
          end
          ST_HOLD_DELAY, ST_HOLD_REPEAT: begin
            if (!dir_lvl) begin
              state <= ST_ADJUST;
            end else if (hold_done) begin
              up_pulse   <= (dir == DIR_UP);
              down_pulse <= (dir == DIR_DOWN);
              state      <= ST_HOLD_REPEAT;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adjust_ctrl_fsm.sv
// Directed bench for adjust_ctrl_fsm with short timing parameters; expected values
// are hand-derived from the tick schedule of each step.
module tb_adjust_ctrl_fsm;

  logic clk = 1'b0;
  logic rst, tick_ms, mode_pulse, sel_in, up_lvl, down_lvl;
  logic adj_active, run_en, sel_pulse, up_pulse, down_pulse, blink, timeout_pulse;

  int n_checks, n_pass, n_fail;
  int n_up, n_dn, n_sel, n_to, n_both;
  logic [31:0] rpt_mask;

  always #5 clk = ~clk;

  adjust_ctrl_fsm #(
    .REPEAT_DELAY_MS (5),
    .REPEAT_RATE_MS  (2),
    .TIMEOUT_MS      (50),
    .BLINK_HALF_MS   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick_ms       (tick_ms),
    .mode_pulse    (mode_pulse),
    .sel_in        (sel_in),
    .up_lvl        (up_lvl),
    .down_lvl      (down_lvl),
    .adj_active    (adj_active),
    .run_en        (run_en),
    .sel_pulse     (sel_pulse),
    .up_pulse      (up_pulse),
    .down_pulse    (down_pulse),
    .blink         (blink),
    .timeout_pulse (timeout_pulse)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (up_pulse)              n_up++;
    if (down_pulse)            n_dn++;
    if (sel_pulse)             n_sel++;
    if (timeout_pulse)         n_to++;
    if (up_pulse && down_pulse) n_both++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1;
      cyc();
      tick_ms = 1'b0;
      cyc();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    n_up = 0; n_dn = 0; n_sel = 0; n_to = 0; n_both = 0;
    rst = 1'b1; tick_ms = 1'b0; mode_pulse = 1'b0; sel_in = 1'b0;
    up_lvl = 1'b0; down_lvl = 1'b0;
    cyc(); cyc();

    // Reset values
    check_bit("rst_run_en",     run_en,        1'b1);
    check_bit("rst_adj_active", adj_active,    1'b0);
    check_bit("rst_blink",      blink,         1'b1);
    check_bit("rst_up_pulse",   up_pulse,      1'b0);
    check_bit("rst_timeout",    timeout_pulse, 1'b0);
    rst = 1'b0;
    cyc();

    // RUN ignores UP and select
    up_lvl = 1'b1; sel_in = 1'b1; cyc();
    sel_in = 1'b0; cyc();
    check_int("run_ignore_up",  n_up,  0);
    check_int("run_ignore_sel", n_sel, 0);
    check_bit("run_stays_run",  adj_active, 1'b0);
    up_lvl = 1'b0; cyc();

    // Enter adjust, single short press
    mode_pulse = 1'b1; cyc(); mode_pulse = 1'b0;
    check_bit("enter_adj_active", adj_active, 1'b1);
    check_bit("enter_run_en",     run_en,     1'b0);
    check_bit("enter_blink",      blink,      1'b1);
    up_lvl = 1'b1; cyc();
    check_bit("press_up_pulse", up_pulse, 1'b1);
    ticks(2);
    up_lvl = 1'b0; cyc(); cyc();
    check_int("single_press_count", n_up, 1);
    check_bit("single_press_adj",   adj_active, 1'b1);

    // Hold 11 ticks: repeats at ticks 5, 7, 9, 11
    n_up = 0;
    up_lvl = 1'b1; cyc();
    check_bit("hold_press_pulse", up_pulse, 1'b1);
    rpt_mask = '0;
    for (int i = 1; i <= 11; i++) begin
      tick_ms = 1'b1; cyc();
      rpt_mask[i] = up_pulse;
      tick_ms = 1'b0; cyc();
    end
    check_int("rpt_tick_mask", int'(rpt_mask), 32'h0000_0AA0);
    check_int("rpt_count",     $countones(rpt_mask), 4);
    up_lvl = 1'b0; cyc(); cyc();
    ticks(3);
    check_int("release_stops_rpt", n_up, 5);
    check_bit("release_in_adj",    adj_active, 1'b1);

    // Simultaneous edges: UP wins, DOWN needs a fresh press
    n_up = 0; n_dn = 0;
    up_lvl = 1'b1; down_lvl = 1'b1; cyc();
    check_bit("sim_up_pulse",   up_pulse,   1'b1);
    check_bit("sim_down_pulse", down_pulse, 1'b0);
    up_lvl = 1'b0; cyc(); cyc();
    ticks(2);
    check_int("held_down_silent", n_dn, 0);
    down_lvl = 1'b0; cyc();
    down_lvl = 1'b1; cyc();
    check_bit("repress_down_pulse", down_pulse, 1'b1);
    check_bit("repress_no_up",      up_pulse,   1'b0);
    up_lvl = 1'b1; cyc(); cyc();
    ticks(1);
    check_int("opposite_ignored", n_up, 1);
    up_lvl = 1'b0; down_lvl = 1'b0; cyc(); cyc();

    // Blink: toggles every 3 ticks, forced high by a pulse
    sel_in = 1'b1; cyc(); sel_in = 1'b0;
    check_bit("sel_pulse_adj", sel_pulse, 1'b1);
    ticks(2); check_bit("blink_t2", blink, 1'b1);
    ticks(1); check_bit("blink_t3", blink, 1'b0);
    ticks(3); check_bit("blink_t6", blink, 1'b1);
    ticks(3); check_bit("blink_t9", blink, 1'b0);
    sel_in = 1'b1; cyc(); sel_in = 1'b0;
    check_bit("blink_forced", blink, 1'b1);
    ticks(2); check_bit("blink_restart_t2", blink, 1'b1);
    ticks(1); check_bit("blink_restart_t3", blink, 1'b0);

    // Idle timeout after 50 ticks
    sel_in = 1'b1; cyc(); sel_in = 1'b0; cyc();
    n_to = 0;
    ticks(49);
    check_int("to_not_early", n_to, 0);
    check_bit("to_still_adj", adj_active, 1'b1);
    tick_ms = 1'b1; cyc();
    check_bit("to_pulse",      timeout_pulse, 1'b1);
    check_bit("to_adj_active", adj_active,    1'b0);
    check_bit("to_run_en",     run_en,        1'b1);
    tick_ms = 1'b0; cyc();
    check_bit("to_one_cycle", timeout_pulse, 1'b0);

    // Select at tick 40 defers the timeout to tick 90
    mode_pulse = 1'b1; cyc(); mode_pulse = 1'b0;
    n_to = 0;
    ticks(40);
    sel_in = 1'b1; cyc(); sel_in = 1'b0;
    check_bit("sel_at_40", sel_pulse, 1'b1);
    ticks(49);
    check_int("to_deferred", n_to, 0);
    tick_ms = 1'b1; cyc();
    check_bit("to_at_90", timeout_pulse, 1'b1);
    tick_ms = 1'b0; cyc();

    // mode_pulse on the repeat-terminal tick wins
    mode_pulse = 1'b1; cyc(); mode_pulse = 1'b0;
    n_up = 0;
    up_lvl = 1'b1; cyc();
    ticks(6);
    check_int("pre_mode_rpt_count", n_up, 2);
    tick_ms = 1'b1; mode_pulse = 1'b1; cyc();
    check_bit("mode_beats_rpt", up_pulse,   1'b0);
    check_bit("mode_exit_adj",  adj_active, 1'b0);
    check_bit("mode_exit_run",  run_en,     1'b1);
    tick_ms = 1'b0; mode_pulse = 1'b0; cyc();
    check_int("mode_no_late_pulse", n_up, 2);
    up_lvl = 1'b0; cyc();

    // Asynchronous reset during HOLD_REPEAT
    mode_pulse = 1'b1; cyc(); mode_pulse = 1'b0;
    up_lvl = 1'b1; cyc();
    ticks(6);
    tick_ms = 1'b1; cyc();
    check_bit("pre_rst_pulse", up_pulse,   1'b1);
    check_bit("pre_rst_adj",   adj_active, 1'b1);
    tick_ms = 1'b0;
    rst = 1'b1;
    #1;
    check_bit("async_rst_up_pulse", up_pulse,   1'b0);
    check_bit("async_rst_adj",      adj_active, 1'b0);
    check_bit("async_rst_run_en",   run_en,     1'b1);
    check_bit("async_rst_blink",    blink,      1'b1);
    cyc();
    rst = 1'b0;
    cyc();
    check_bit("post_rst_adj",      adj_active, 1'b0);
    check_bit("post_rst_up_pulse", up_pulse,   1'b0);
    check_bit("post_rst_run_en",   run_en,     1'b1);
    up_lvl = 1'b0; cyc();

    check_int("pulse_exclusive", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
